// File: rtl/logic_unit_scheduler.sv
// Issue/writeback controller for the shared combinational logic unit:
// round-robin issue from the RS entries into EX, then a WB buffer held on the CDB until acked.
module logic_unit_scheduler #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_RS-1:0]          req_valid_i,
  input  logic [2*NUM_RS-1:0]        req_op_i,
  input  logic [DATA_W*NUM_RS-1:0]   req_a_i,
  input  logic [DATA_W*NUM_RS-1:0]   req_b_i,
  input  logic [TAG_W*NUM_RS-1:0]    req_tag_i,
  output logic [NUM_RS-1:0]          grant_o,
  output logic [1:0]                 lu_op_o,
  output logic [DATA_W-1:0]          lu_a_o,
  output logic [DATA_W-1:0]          lu_b_o,
  input  logic [DATA_W-1:0]          lu_result_i,
  output logic                       cdb_valid_o,
  output logic [TAG_W-1:0]           cdb_tag_o,
  output logic [DATA_W-1:0]          cdb_data_o,
  input  logic                       cdb_ack_i,
  output logic                       busy_o
);

  localparam int RR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [RR_W-1:0]   rr_q, rr_d;
  logic              ex_v_q, ex_v_d;
  logic [1:0]        ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [TAG_W-1:0]  ex_tag_q, ex_tag_d;
  logic              wb_v_q, wb_v_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              wb_free, ex_adv, ex_free;
  logic              grant_any;
  logic [RR_W-1:0]   grant_idx;
  logic [NUM_RS-1:0] grant;

  assign wb_free = !wb_v_q || cdb_ack_i;
  assign ex_adv  = ex_v_q && wb_free;
  assign ex_free = !ex_v_q || ex_adv;

  // Gated by reset so GRANT reads zero while the core is held in reset.
  always_comb begin : arbiter
    int            idx;
    logic [RR_W-1:0] idx_w;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = 0;
    idx_w     = '0;
    if (rst_n_i && ex_free) begin
      for (int k = 0; k < NUM_RS; k++) begin
        idx   = (int'(rr_q) + k) % NUM_RS;
        idx_w = RR_W'(idx);
        if (!grant_any && req_valid_i[idx_w]) begin
          grant_any = 1'b1;
          grant_idx = idx_w;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin : next_state
    rr_d      = rr_q;
    ex_v_d    = ex_v_q;
    ex_op_d   = ex_op_q;
    ex_a_d    = ex_a_q;
    ex_b_d    = ex_b_q;
    ex_tag_d  = ex_tag_q;
    wb_v_d    = wb_v_q;
    wb_tag_d  = wb_tag_q;
    wb_data_d = wb_data_q;

    if (ex_adv) begin
      wb_v_d    = 1'b1;
      wb_tag_d  = ex_tag_q;
      wb_data_d = lu_result_i;
      ex_v_d    = 1'b0;
    end else if (cdb_ack_i && wb_v_q) begin
      wb_v_d = 1'b0;
    end

    // A grant refills EX in the same cycle it drains.
    if (grant_any) begin
      ex_v_d = 1'b1;
      rr_d   = (int'(grant_idx) == NUM_RS - 1) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < NUM_RS; i++) begin
        if (grant[i]) begin
          ex_op_d  = req_op_i[2*i +: 2];
          ex_a_d   = req_a_i[DATA_W*i +: DATA_W];
          ex_b_d   = req_b_i[DATA_W*i +: DATA_W];
          ex_tag_d = req_tag_i[TAG_W*i +: TAG_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q      <= '0;
      ex_v_q    <= 1'b0;
      ex_op_q   <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      ex_tag_q  <= '0;
      wb_v_q    <= 1'b0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      ex_v_q    <= ex_v_d;
      ex_op_q   <= ex_op_d;
      ex_a_q    <= ex_a_d;
      ex_b_q    <= ex_b_d;
      ex_tag_q  <= ex_tag_d;
      wb_v_q    <= wb_v_d;
      wb_tag_q  <= wb_tag_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign grant_o     = grant;
  assign lu_op_o     = ex_op_q;
  assign lu_a_o      = ex_a_q;
  assign lu_b_o      = ex_b_q;
  assign cdb_valid_o = wb_v_q;
  assign cdb_tag_o   = wb_tag_q;
  assign cdb_data_o  = wb_data_q;
  assign busy_o      = ex_v_q || wb_v_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Bench for logic_unit_scheduler: acts as the logic unit and scoreboards every CDB result.
module tb_logic_unit_scheduler;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [7:0]    req_op;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [15:0]   req_tag;
  logic [3:0]    grant;
  logic [1:0]    lu_op;
  logic [31:0]   lu_a;
  logic [31:0]   lu_b;
  logic [31:0]   lu_result;
  logic          cdb_valid;
  logic [3:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          cdb_ack;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0]  exp_tag[$];
  logic [31:0] exp_data[$];

  logic_unit_scheduler #(.NUM_RS(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .req_tag_i(req_tag), .grant_o(grant),
    .lu_op_o(lu_op), .lu_a_o(lu_a), .lu_b_o(lu_b), .lu_result_i(lu_result),
    .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data),
    .cdb_ack_i(cdb_ack), .busy_o(busy)
  );

  function automatic logic [31:0] lu_model(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign lu_result = lu_model(lu_op, lu_a, lu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: whatever sits on the CDB must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      n_assert++;
      if (exp_tag.size() == 0) begin
        n_fail++;
        $display("FAIL cdb_unexpected: got tag=%0h data=%08h, expected no result", cdb_tag, cdb_data);
      end else begin
        if (cdb_tag !== exp_tag[0] || cdb_data !== exp_data[0]) begin
          n_fail++;
          $display("FAIL cdb_result: got tag=%0h data=%08h, expected tag=%0h data=%08h",
                   cdb_tag, cdb_data, exp_tag[0], exp_data[0]);
        end
        if (cdb_ack) begin
          void'(exp_tag.pop_front());
          void'(exp_data.pop_front());
        end
      end
    end
  end

  task automatic set_entry(input int i, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
    req_op[2*i +: 2]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_tag[4*i +: 4]  = tag;
  endtask

  task automatic push_entry(input int i);
    exp_tag.push_back(req_tag[4*i +: 4]);
    exp_data.push_back(lu_model(req_op[2*i +: 2], req_a[32*i +: 32], req_b[32*i +: 32]));
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    cdb_ack   = 1'b0;
    exp_tag.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    cdb_ack = 1'b1;
    for (int i = 0; i < 4; i++) set_entry(i, 2'(i), 32'h1234_0000 + i, 32'hFFFF_0000, 4'(i + 1));
    req_valid = 4'b1111;
    #12;
    n_assert++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_assert++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid: got %b expected 0", cdb_valid); end
    n_assert++; if (cdb_tag !== 4'h0) begin n_fail++; $display("FAIL reset_cdb_tag: got %h expected 0", cdb_tag); end
    n_assert++; if (cdb_data !== 32'h0) begin n_fail++; $display("FAIL reset_cdb_data: got %h expected 0", cdb_data); end
    n_assert++; if (lu_op !== 2'b00) begin n_fail++; $display("FAIL reset_lu_op: got %b expected 00", lu_op); end
    n_assert++; if (lu_a !== 32'h0) begin n_fail++; $display("FAIL reset_lu_a: got %h expected 0", lu_a); end
    n_assert++; if (lu_b !== 32'h0) begin n_fail++; $display("FAIL reset_lu_b: got %h expected 0", lu_b); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", grant); end
    push_entry(0);
    @(posedge clk); #1 req_valid = '0; cdb_ack = 1'b1;
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_reset: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_single();
    int k;
    apply_reset();
    @(posedge clk); #1;
    set_entry(1, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5);
    req_valid = 4'b0010;
    @(negedge clk);
    n_assert++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b expected 0010", grant); end
    push_entry(1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_assert++; if (busy !== 1'b1 || cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_ex_stage: got busy=%b cdb_valid=%b expected 1/0", busy, cdb_valid); end
    n_assert++; if (lu_op !== 2'b00 || lu_a !== 32'hF0F0_1234 || lu_b !== 32'h0FF0_FFFF) begin
      n_fail++; $display("FAIL single_lu_drive: got op=%b a=%h b=%h expected 00/f0f01234/0ff0ffff", lu_op, lu_a, lu_b); end
    @(posedge clk); #1 cdb_ack = 1'b1;
    @(negedge clk);
    n_assert++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 32'h00F0_1234) begin
      n_fail++; $display("FAIL single_cdb: got v=%b tag=%0h data=%h expected 1/5/00f01234", cdb_valid, cdb_tag, cdb_data); end
    @(posedge clk); #1 cdb_ack = 1'b1;
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_single: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_ops_sweep();
    int k;
    logic [1:0]  ops[3];
    logic [31:0] exp_d[3];
    ops   = '{2'b01, 2'b10, 2'b11};
    exp_d = '{32'hAAAA_FFFF, 32'hAAAA_5555, 32'h5555_5555};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cdb_ack = 1'b1;
      if (c < 3) begin
        set_entry(0, ops[c], 32'hAAAA_AAAA, 32'h0000_FFFF, 4'(c + 1));
        req_valid = 4'b0001;
      end else req_valid = '0;
      @(negedge clk);
      if (c < 3) begin
        n_assert++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ops_grant_%0d: got %b expected 0001", c, grant); end
        push_entry(0);
      end
      if (c >= 2) begin
        n_assert++; if (cdb_valid !== 1'b1 || cdb_data !== exp_d[c-2]) begin
          n_fail++; $display("FAIL ops_result_%0d: got v=%b data=%h expected 1/%h", c - 2, cdb_valid, cdb_data, exp_d[c-2]); end
      end
    end
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_ops: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_round_robin();
    int k;
    logic [3:0] eg;
    apply_reset();
    for (int i = 0; i < 4; i++)
      set_entry(i, 2'(i), 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F ^ i, 4'(8 + i));
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      cdb_ack   = 1'b1;
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 5) begin
        eg = 4'b0001 << (c % 4);
        n_assert++; if (grant !== eg) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", c, grant, eg); end
        push_entry(c % 4);
      end
      if (c >= 2) begin
        n_assert++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL rr_throughput_%0d: got cdb_valid=%b expected 1", c, cdb_valid); end
      end
    end
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_rr: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_backpressure();
    int k;
    logic [3:0] vmask[8];
    logic [3:0] eg[8];
    vmask = '{4'b0111, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    eg    = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    apply_reset();
    set_entry(0, 2'b10, 32'hDEAD_BEEF, 32'h0123_4567, 4'd1);
    set_entry(1, 2'b01, 32'h8000_0001, 32'h0000_F000, 4'd2);
    set_entry(2, 2'b11, 32'h0F0F_00FF, 32'hFFFF_FFFF, 4'd3);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      cdb_ack   = (c >= 5);
      req_valid = vmask[c];
      @(negedge clk);
      n_assert++; if (grant !== eg[c]) begin n_fail++; $display("FAIL bp_grant_%0d: got %b expected %b", c, grant, eg[c]); end
      if (eg[c] == 4'b0001) push_entry(0);
      if (eg[c] == 4'b0010) push_entry(1);
      if (eg[c] == 4'b0100) push_entry(2);
      if (c >= 2) begin
        n_assert++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_cdb_valid_%0d: got %b expected 1", c, cdb_valid); end
      end
    end
    @(posedge clk); #1 cdb_ack = 1'b1;
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_bp: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_wrap_around();
    int k;
    logic [3:0] vmask[4];
    logic [3:0] eg[4];
    vmask = '{4'b0100, 4'b0101, 4'b0101, 4'b0000};
    eg    = '{4'b0100, 4'b0001, 4'b0100, 4'b0000};
    apply_reset();
    set_entry(0, 2'b00, 32'hCAFE_F00D, 32'hFF00_FF00, 4'd7);
    set_entry(2, 2'b10, 32'h1357_9BDF, 32'h2468_ACE0, 4'd9);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      cdb_ack   = 1'b1;
      req_valid = vmask[c];
      @(negedge clk);
      n_assert++; if (grant !== eg[c]) begin n_fail++; $display("FAIL wrap_grant_%0d: got %b expected %b", c, grant, eg[c]); end
      if (eg[c] == 4'b0001) push_entry(0);
      if (eg[c] == 4'b0100) push_entry(2);
    end
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_wrap: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  task automatic test_async_reset();
    int k;
    apply_reset();
    for (int i = 0; i < 4; i++)
      set_entry(i, 2'b01, 32'h0000_0F00 << i, 32'h0000_00F0, 4'(12 + i));
    @(posedge clk); #1 req_valid = 4'b0001;
    @(negedge clk);
    n_assert++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ar_grant0: got %b expected 0001", grant); end
    push_entry(0);
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    n_assert++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL ar_grant1: got %b expected 0010", grant); end
    push_entry(1);
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    n_assert++; if (busy !== 1'b1 || cdb_valid !== 1'b1) begin n_fail++; $display("FAIL ar_full: got busy=%b cdb_valid=%b expected 1/1", busy, cdb_valid); end
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1000;
    #1;
    n_assert++; if (cdb_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin
      n_fail++; $display("FAIL ar_immediate: got cdb_valid=%b busy=%b grant=%b expected 0/0/0000", cdb_valid, busy, grant); end
    exp_tag.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    n_assert++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ar_first_grant: got %b expected 0001", grant); end
    push_entry(0);
    @(posedge clk); #1 req_valid = '0; cdb_ack = 1'b1;
    k = 0;
    while ((exp_tag.size() != 0 || busy) && k < 20) begin @(negedge clk); k++; end
    n_assert++; if (exp_tag.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_ar: pending=%0d busy=%b expected 0/0", exp_tag.size(), busy); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    cdb_ack   = 1'b0;
    test_reset();
    test_single();
    test_ops_sweep();
    test_round_robin();
    test_backpressure();
    test_wrap_around();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
